// File: rtl/pose_pkg.sv
// Shared constants, state type and sine-table generator for the pose trig stage.
// Angles are unsigned 4.8 fixed point with a full turn at 12'h648; trig values are Q2.14.
package pose_pkg;

    localparam logic [11:0] ANG_HALF_PI  = 12'h192;
    localparam logic [11:0] ANG_PI       = 12'h324;
    localparam logic [11:0] ANG_3HALF_PI = 12'h4B6;
    localparam logic [11:0] ANG_2PI      = 12'h648;

    localparam logic [15:0] TRIG_ONE  = 16'h4000;
    localparam int unsigned ROM_DEPTH = 403;

    // pi in Q30, used only by the elaboration-time table generator
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic [1:0] {IDLE, CALC, VALID} pose_state_t;

    // round(sin(idx*2pi/1608) * 2^14) via an odd Taylor series in Q30; constant-folded.
    function automatic logic [15:0] sine_entry(input int unsigned idx);
        longint xq;
        longint x2;
        longint term;
        longint sum;
        longint res;
        if (idx >= ROM_DEPTH) begin
            return 16'h0000;
        end
        if (idx == ROM_DEPTH - 1) begin
            return TRIG_ONE;
        end
        xq   = (longint'(idx) * PI_Q30) / 64'sd804;
        x2   = (xq * xq) >>> 30;
        term = xq;
        sum  = xq;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        res = (sum + 64'sd32768) >>> 16;
        return 16'(res);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous quarter-wave sine ROM, 403 live entries behind a 9-bit address, 1-cycle latency.
// Contents are generated at elaboration time from the package table function.
module sine_quarter_rom
    import pose_pkg::*;
#(
    parameter int unsigned TW = 16
) (
    input  logic          Clk,
    input  logic [8:0]    addr,
    output logic [TW-1:0] data
);

    logic [TW-1:0] rom_w [512];

    for (genvar i = 0; i < 512; i++) begin : g_rom
        localparam logic [15:0] entry = sine_entry(i);
        assign rom_w[i] = TW'(entry);
    end

    always_ff @(posedge Clk) begin
        data <= rom_w[addr];
    end

endmodule

// File: rtl/pose_trig_stage.sv
// Latches a pose on each frame strobe, evaluates sin/cos of the three angles through one
// shared quarter-wave ROM, and offers the bundle downstream on a valid/ready handshake.
module pose_trig_stage
    import pose_pkg::*;
#(
    parameter int unsigned WI = 8,
    parameter int unsigned WF = 8,
    parameter int unsigned AW = 12,
    parameter int unsigned TW = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk_rising_edge,
    input  logic [AW-1:0]    alpha,
    input  logic [AW-1:0]    beta,
    input  logic [AW-1:0]    gamma,
    input  logic [WI+WF-1:0] x,
    input  logic [WI+WF-1:0] y,
    input  logic [WI+WF-1:0] z,
    input  logic             pose_ready,
    output logic             pose_valid,
    output logic [TW-1:0]    sin_a,
    output logic [TW-1:0]    cos_a,
    output logic [TW-1:0]    sin_b,
    output logic [TW-1:0]    cos_b,
    output logic [TW-1:0]    sin_g,
    output logic [TW-1:0]    cos_g,
    output logic [WI+WF-1:0] x_o,
    output logic [WI+WF-1:0] y_o,
    output logic [WI+WF-1:0] z_o,
    output logic             frame_drop
);

    localparam int unsigned PW = WI + WF;

    localparam logic [AW-1:0] A_HALF  = AW'(ANG_HALF_PI);
    localparam logic [AW-1:0] A_PI    = AW'(ANG_PI);
    localparam logic [AW-1:0] A_3HALF = AW'(ANG_3HALF_PI);
    localparam logic [AW-1:0] A_2PI   = AW'(ANG_2PI);

    pose_state_t   state_q, state_d;
    logic [2:0]    cnt_q;
    logic          pending_q;
    logic [AW-1:0] alpha_q, beta_q, gamma_q;
    logic [PW-1:0] x_q, y_q, z_q;
    logic [TW-1:0] shadow_q [6];
    logic          neg_q;

    logic          start, capture, load_out, accept;
    logic [AW-1:0] ang_sel, ang_red, ang_sum, ang_eff, ang_diff;
    logic [8:0]    rom_addr;
    logic          rom_neg;
    logic [TW-1:0] rom_data, trig_val;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_clk_rising_edge || pending_q) state_d = CALC;
            CALC:    if (cnt_q == 3'd6) state_d = VALID;
            VALID:   if (pose_valid && pose_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        capture  = 1'b0;
        load_out = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE:    start = frame_clk_rising_edge | pending_q;
            CALC: begin
                capture  = (cnt_q != 3'd0);
                load_out = (cnt_q == 3'd6);
            end
            VALID:   accept = pose_valid & pose_ready;
            default: ;
        endcase
    end

    assign frame_drop = frame_clk_rising_edge & pending_q & (state_q != IDLE);

    // ---------------- Lookup address and quadrant ----------------
    // Even cnt selects sin, odd cnt selects cos; cnt[2:1] picks the angle.
    always_comb begin
        unique case (cnt_q[2:1])
            2'd0:    ang_sel = alpha_q;
            2'd1:    ang_sel = beta_q;
            default: ang_sel = gamma_q;
        endcase
        ang_red = (ang_sel >= A_2PI) ? ang_sel - A_2PI : ang_sel;
        ang_sum = ang_red + A_HALF;
        if (cnt_q[0]) begin
            ang_eff = (ang_sum >= A_2PI) ? ang_sum - A_2PI : ang_sum;
        end else begin
            ang_eff = ang_red;
        end
        rom_neg = 1'b0;
        if (ang_eff < A_HALF) begin
            ang_diff = ang_eff;
        end else if (ang_eff < A_PI) begin
            ang_diff = A_PI - ang_eff;
        end else if (ang_eff < A_3HALF) begin
            ang_diff = ang_eff - A_PI;
            rom_neg  = 1'b1;
        end else begin
            ang_diff = A_2PI - ang_eff;
            rom_neg  = 1'b1;
        end
        rom_addr = 9'(ang_diff);
    end

    sine_quarter_rom #(
        .TW (TW)
    ) u_rom (
        .Clk  (Clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // The sign travels one cycle behind the address so it lines up with the ROM data.
    assign trig_val = neg_q ? ({TW{1'b0}} - rom_data) : rom_data;

    // ---------------- Working registers ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= 3'd0;
            pending_q <= 1'b0;
            neg_q     <= 1'b0;
            alpha_q   <= '0;
            beta_q    <= '0;
            gamma_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            neg_q <= rom_neg;
            if (start) begin
                alpha_q <= alpha;
                beta_q  <= beta;
                gamma_q <= gamma;
                x_q     <= x;
                y_q     <= y;
                z_q     <= z;
                cnt_q   <= 3'd0;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (start) begin
                pending_q <= 1'b0;
            end else if (frame_clk_rising_edge && state_q != IDLE) begin
                pending_q <= 1'b1;
            end
            if (capture) begin
                shadow_q[cnt_q - 3'd1] <= trig_val;
            end
        end
    end

    // ---------------- Output bundle ----------------
    // cos_g is taken straight from the capture path: its shadow is written in the same cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pose_valid <= 1'b0;
            sin_a      <= '0;
            cos_a      <= TW'(TRIG_ONE);
            sin_b      <= '0;
            cos_b      <= TW'(TRIG_ONE);
            sin_g      <= '0;
            cos_g      <= TW'(TRIG_ONE);
            x_o        <= '0;
            y_o        <= '0;
            z_o        <= '0;
        end else if (load_out) begin
            pose_valid <= 1'b1;
            sin_a      <= shadow_q[0];
            cos_a      <= shadow_q[1];
            sin_b      <= shadow_q[2];
            cos_b      <= shadow_q[3];
            sin_g      <= shadow_q[4];
            cos_g      <= trig_val;
            x_o        <= x_q;
            y_o        <= y_q;
            z_o        <= z_q;
        end else if (accept) begin
            pose_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pose_trig_stage.sv
// Scoreboard bench for pose_trig_stage: a real-valued sin/cos model feeds a queue that a
// free-running monitor drains on each accepted pose.
module tb_pose_trig_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [11:0] alpha = '0, beta = '0, gamma = '0;
    logic [15:0] x = '0, y = '0, z = '0;
    logic        pose_ready = 1'b1;
    logic        pose_valid, frame_drop;
    logic [15:0] sin_a, cos_a, sin_b, cos_b, sin_g, cos_g, x_o, y_o, z_o;

    always #5 clk = ~clk;

    pose_trig_stage #(
        .WI (8),
        .WF (8),
        .AW (12),
        .TW (16)
    ) dut (
        .Clk                   (clk),
        .Reset                 (rst),
        .frame_clk_rising_edge (strobe),
        .alpha                 (alpha),
        .beta                  (beta),
        .gamma                 (gamma),
        .x                     (x),
        .y                     (y),
        .z                     (z),
        .pose_ready            (pose_ready),
        .pose_valid            (pose_valid),
        .sin_a                 (sin_a),
        .cos_a                 (cos_a),
        .sin_b                 (sin_b),
        .cos_b                 (cos_b),
        .sin_g                 (sin_g),
        .cos_g                 (cos_g),
        .x_o                   (x_o),
        .y_o                   (y_o),
        .z_o                   (z_o),
        .frame_drop            (frame_drop)
    );

    typedef struct {
        logic [15:0] sa, ca, sb, cb, sg, cg;
        logic [15:0] px, py, pz;
        int          tol;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   drops = 0;

    function automatic logic [15:0] ref_trig(input logic [11:0] ang, input bit want_cos);
        real th, v;
        int  r;
        th = real'(ang) * 6.283185307179586 / 1608.0;
        v  = want_cos ? $cos(th) : $sin(th);
        r  = int'($floor(v * 16384.0 + 0.5));
        return 16'(r);
    endfunction

    function automatic exp_t make_exp(input logic [11:0] a, input logic [11:0] b,
                                      input logic [11:0] g, input logic [15:0] px,
                                      input logic [15:0] py, input logic [15:0] pz,
                                      input int tol);
        exp_t e;
        e.sa = ref_trig(a, 1'b0);
        e.ca = ref_trig(a, 1'b1);
        e.sb = ref_trig(b, 1'b0);
        e.cb = ref_trig(b, 1'b1);
        e.sg = ref_trig(g, 1'b0);
        e.cg = ref_trig(g, 1'b1);
        e.px = px;
        e.py = py;
        e.pz = pz;
        e.tol = tol;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp,
                       input int tol);
        int d;
        tests++;
        d = int'($signed(act)) - int'($signed(exp));
        if (d > tol || d < -tol) begin
            fails++;
            $display("FAIL %s: actual %h required %h (tol %0d) at %0t", name, act, exp, tol,
                     $time);
        end
    endtask

    task automatic chk_bundle(input string tag, input exp_t e);
        chk({tag, ".sin_a"}, sin_a, e.sa, e.tol);
        chk({tag, ".cos_a"}, cos_a, e.ca, e.tol);
        chk({tag, ".sin_b"}, sin_b, e.sb, e.tol);
        chk({tag, ".cos_b"}, cos_b, e.cb, e.tol);
        chk({tag, ".sin_g"}, sin_g, e.sg, e.tol);
        chk({tag, ".cos_g"}, cos_g, e.cg, e.tol);
        chk({tag, ".x_o"}, x_o, e.px, 0);
        chk({tag, ".y_o"}, y_o, e.py, 0);
        chk({tag, ".z_o"}, z_o, e.pz, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 16'(pose_valid), 16'd0, 0);
        chk({tag, ".drop"}, 16'(frame_drop), 16'd0, 0);
        chk({tag, ".sin_a"}, sin_a, 16'h0000, 0);
        chk({tag, ".cos_a"}, cos_a, 16'h4000, 0);
        chk({tag, ".sin_b"}, sin_b, 16'h0000, 0);
        chk({tag, ".cos_b"}, cos_b, 16'h4000, 0);
        chk({tag, ".sin_g"}, sin_g, 16'h0000, 0);
        chk({tag, ".cos_g"}, cos_g, 16'h4000, 0);
        chk({tag, ".x_o"}, x_o, 16'h0000, 0);
        chk({tag, ".y_o"}, y_o, 16'h0000, 0);
        chk({tag, ".z_o"}, z_o, 16'h0000, 0);
    endtask

    // Monitor: every accepted pose must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && frame_drop) drops++;
        if (!rst && pose_valid && pose_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 16'd1, 16'd0, 0);
            end else begin
                e = sb_q.pop_front();
                chk_bundle("pose", e);
            end
        end
    end

    task automatic set_inputs(input logic [11:0] a, input logic [11:0] b, input logic [11:0] g,
                              input logic [15:0] px, input logic [15:0] py,
                              input logic [15:0] pz);
        alpha = a;
        beta  = b;
        gamma = g;
        x     = px;
        y     = py;
        z     = pz;
    endtask

    // Issue one frame and wait (bounded) for its handshake; lat = first cycle with valid.
    task automatic run_frame(input logic [11:0] a, input logic [11:0] b, input logic [11:0] g,
                             input logic [15:0] px, input logic [15:0] py,
                             input logic [15:0] pz, input int tol, input bit rand_ready,
                             output int lat);
        bit done;
        @(posedge clk); #1;
        set_inputs(a, b, g, px, py, pz);
        strobe = 1'b1;
        sb_q.push_back(make_exp(a, b, g, px, py, pz, tol));
        @(posedge clk); #1;
        strobe = 1'b0;
        lat  = -1;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (rand_ready) pose_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pose_valid && lat < 0) lat = k;
            if (pose_valid && pose_ready) done = 1'b1;
        end
        chk("handshake_seen", 16'(done), 16'd1, 0);
        @(posedge clk); #1;
        pose_ready = 1'b1;
    endtask

    function automatic logic [11:0] rnd_ang();
        return 12'($urandom_range(0, 12'h648));
    endfunction

    initial begin
        int   lat;
        int   drops0;
        bit   seen;
        exp_t e;

        // 1: reset and idle
        pose_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid", 16'(pose_valid), 16'd0, 0);
        end

        // 2: zero angles, latency
        run_frame(12'h000, 12'h000, 12'h000, 16'h1234, 16'h00FF, 16'hFC00, 0, 1'b0, lat);
        chk("latency", 16'(lat), 16'd8, 0);
        @(negedge clk);
        chk("valid_drop_cycle9", 16'(pose_valid), 16'd0, 0);

        // 3: quadrant points and full-turn alias
        run_frame(12'h192, 12'h324, 12'h4B6, 16'hA5A5, 16'h5A5A, 16'h8001, 0, 1'b0, lat);
        run_frame(12'h648, 12'h000, 12'h648, 16'h7FFF, 16'h8000, 16'h0001, 0, 1'b0, lat);

        // sweeps and random poses with random backpressure
        for (int i = 0; i <= 12'h648; i += 12'h33) begin
            run_frame(12'(i), 12'(12'h648 - i), rnd_ang(), 16'($urandom), 16'($urandom),
                      16'($urandom), 1, 1'b1, lat);
        end
        for (int i = 0; i < 12; i++) begin
            run_frame(rnd_ang(), rnd_ang(), rnd_ang(), 16'($urandom), 16'($urandom),
                      16'($urandom), 1, 1'b1, lat);
        end

        // 4: backpressure for 30 cycles with changing inputs
        @(posedge clk); #1;
        pose_ready = 1'b0;
        set_inputs(12'h324, 12'h192, 12'h000, 16'h1111, 16'h2222, 16'h3333);
        e = make_exp(12'h324, 12'h192, 12'h000, 16'h1111, 16'h2222, 16'h3333, 0);
        sb_q.push_back(e);
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = pose_valid;
        end
        chk("bp_valid_seen", 16'(seen), 16'd1, 0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            set_inputs(rnd_ang(), rnd_ang(), rnd_ang(), 16'($urandom), 16'($urandom),
                       16'($urandom));
            @(negedge clk);
            chk("bp_hold_valid", 16'(pose_valid), 16'd1, 0);
            chk_bundle("bp_hold", e);
        end
        @(posedge clk); #1;
        pose_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accepted_first_ready", 16'(sb_q.size()), 16'd0, 0);
        @(negedge clk);
        chk("bp_valid_low", 16'(pose_valid), 16'd0, 0);

        // 5: two strobes in VALID under backpressure; restart latches current inputs
        drops0 = drops;
        @(posedge clk); #1;
        pose_ready = 1'b0;
        set_inputs(12'h100, 12'h200, 12'h300, 16'h0A0A, 16'h0B0B, 16'h0C0C);
        sb_q.push_back(make_exp(12'h100, 12'h200, 12'h300, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1));
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = pose_valid;
        end
        chk("pend_valid_seen", 16'(seen), 16'd1, 0);
        @(posedge clk); #1;
        set_inputs(12'h050, 12'h060, 12'h070, 16'hDEAD, 16'hBEEF, 16'hCAFE);
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        @(posedge clk); #1;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        set_inputs(12'h5A0, 12'h3C0, 12'h123, 16'h4321, 16'h8765, 16'hFEDC);
        sb_q.push_back(make_exp(12'h5A0, 12'h3C0, 12'h123, 16'h4321, 16'h8765, 16'hFEDC, 1));
        repeat (3) @(posedge clk);
        #1 pose_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) break;
        end
        chk("pend_drained", 16'(sb_q.size()), 16'd0, 0);
        chk("drop_count", 16'(drops - drops0), 16'd1, 0);
        repeat (3) @(posedge clk);

        // 6: reset during CALC cycle cnt=3
        #1;
        set_inputs(12'h0AA, 12'h1BB, 12'h2CC, 16'h1357, 16'h2468, 16'h9ABC);
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset("mid_calc_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_idle_valid", 16'(pose_valid), 16'd0, 0);
        end
        run_frame(rnd_ang(), rnd_ang(), rnd_ang(), 16'($urandom), 16'($urandom),
                  16'($urandom), 1, 1'b0, lat);
        chk("recover_latency", 16'(lat), 16'd8, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 16'(sb_q.size()), 16'd0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
